apb_command_sequencer: RTL

- Small APB requester that replaces the manual edge-detect transaction logic driving the completer side of the GTY APB bridge.
- Accepts read/write commands through a valid/ready interface and buffers them in a command FIFO.
- Issues each command as one compliant APB transfer, then returns a single-cycle response with read data, slave error and timeout status.
- Runs in the bridge TX clock domain and sits directly upstream of the bridge's apb_comp port.

---
 rtl/apb_command_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_command_sequencer.sv
// apb_command_sequencer: APB requester fed by a valid/ready command FIFO.
// Each queued command becomes one APB transfer (IDLE -> SETUP -> ACCESS),
// followed by a one-cycle response strobe carrying read data and status.
// Optional build macro APB_CMD_SEQ_STATS_EN adds saturating response counters
// with a synchronous clear input.
module apb_command_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
`ifdef APB_CMD_SEQ_STATS_EN
  input  logic                  stat_clear,
  output logic [31:0]           stat_ok,
  output logic [31:0]           stat_slverr,
  output logic [31:0]           stat_timeout,
`endif
  output logic                  apb_psel,
  output logic                  apb_penable,
  output logic                  apb_pwrite,
  output logic [ADDR_WIDTH-1:0] apb_paddr,
  output logic [DATA_WIDTH-1:0] apb_pwdata,
  input  logic                  apb_pready,
  input  logic [DATA_WIDTH-1:0] apb_prdata,
  input  logic                  apb_pslverr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  // Command FIFO: storage plus pointers carrying an extra wrap bit.
  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          empty, push, pop;

  state_e                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_to_q, rsp_to_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = cmd_valid && cmd_ready_q;
  assign pop   = (state_q == IDLE) && !empty;

  // Next FIFO pointers and the registered not-full flag they imply.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    cmd_ready_d = !((wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                    (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]));
  end

  // FIFO pointer and ready registers.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  // Transfer FSM next-state, command capture, timeout count and response.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          cmd_d   = mem_q[rd_ptr_q[PW-1:0]];
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb_pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = cmd_q.write ? '0 : apb_prdata;
          rsp_err_d   = apb_pslverr;
          rsp_to_d    = 1'b0;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, command register, counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = !empty || (state_q != IDLE);
  assign apb_psel    = (state_q != IDLE);
  assign apb_penable = (state_q == ACCESS);
  assign apb_pwrite  = cmd_q.write;
  assign apb_paddr   = cmd_q.addr;
  assign apb_pwdata  = cmd_q.write ? cmd_q.wdata : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;

`ifdef APB_CMD_SEQ_STATS_EN
  logic [31:0] stat_ok_q, stat_slverr_q, stat_timeout_q;

  // Saturating response counters; a timeout is counted only as a timeout.
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_ok_q      <= '0;
      stat_slverr_q  <= '0;
      stat_timeout_q <= '0;
    end else if (rsp_valid_q) begin
      if (rsp_to_q) begin
        if (stat_timeout_q != '1) stat_timeout_q <= stat_timeout_q + 1'b1;
      end else if (rsp_err_q) begin
        if (stat_slverr_q != '1) stat_slverr_q <= stat_slverr_q + 1'b1;
      end else begin
        if (stat_ok_q != '1) stat_ok_q <= stat_ok_q + 1'b1;
      end
    end
  end

  assign stat_ok      = stat_ok_q;
  assign stat_slverr  = stat_slverr_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule
